ram_arbiter: RTL and testbench

Two-requester round-robin arbiter and access sequencer for the single-port 256x32 synchronous RAM (`ram`).
Each requester (e.g. datapath and loader/DMA) issues one read or write per req/ack handshake.
The arbiter latches the winning request, drives the RAM port, waits out the read latency, returns read data and pulses ack.
It sits between the requesters and the `ram` instance; it is the only driver of the RAM port.

---
 rtl/ram_arbiter.sv | 116 +++++++++++
 tb/tb_ram_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_arbiter : two-requester round-robin arbiter / access sequencer for a
//               single-port synchronous RAM.  Revision 1.0
// ----------------------------------------------------------------------------
module ram_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic [ADDR_W-1:0] ramAddr,
   output logic [DATA_W-1:0] ramDataIn,
   output logic              ramWrEnable,
   input  logic [DATA_W-1:0] ramDataOut
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

   state_t     state;
   logic       sel;
   logic       we_lat;
   logic       last_grant;
   logic [1:0] wait_cnt;
   logic       grant;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant = (req0 && req1) ? ~last_grant : req1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sel         <= 1'b0;
         we_lat      <= 1'b0;
         last_grant  <= 1'b1;
         wait_cnt    <= 2'd0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         rdata0      <= '0;
         rdata1      <= '0;
         ramAddr     <= '0;
         ramDataIn   <= '0;
         ramWrEnable <= 1'b0;
         busy        <= 1'b0;
      end else begin
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         ramWrEnable <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  sel         <= grant;
                  last_grant  <= grant;
                  we_lat      <= grant ? we1 : we0;
                  ramAddr     <= grant ? addr1 : addr0;
                  ramDataIn   <= grant ? wdata1 : wdata0;
                  ramWrEnable <= grant ? we1 : we0;
                  busy        <= 1'b1;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               if (we_lat) begin
                  ack0  <= ~sel;
                  ack1  <= sel;
                  state <= DONE;
               end else begin
                  wait_cnt <= WAIT_INIT;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt != 2'd0) begin
                  wait_cnt <= wait_cnt - 1'b1;
               end else begin
                  if (sel) rdata1 <= ramDataOut;
                  else     rdata0 <= ramDataOut;
                  ack0  <= ~sel;
                  ack1  <= sel;
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// tb_ram_arbiter : table-driven and scoreboard bench for ram_arbiter with a
//                  behavioural RAM of configurable read latency.
module tb_ram_arbiter;
   localparam int RD_LAT = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [7:0]  addr0 = '0, addr1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1, busy, ramWrEnable;
   logic [31:0] rdata0, rdata1, ramDataIn, ramDataOut;
   logic [7:0]  ramAddr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   ram_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
      .busy(busy), .ramAddr(ramAddr), .ramDataIn(ramDataIn),
      .ramWrEnable(ramWrEnable), .ramDataOut(ramDataOut)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural RAM: dataOut valid RD_LAT cycles after the address edge
   logic [31:0] mem  [256];
   logic [31:0] pipe [RD_LAT];
   always @(posedge clk) begin
      if (ramWrEnable) mem[ramAddr] <= ramDataIn;
      pipe[0] <= mem[ramAddr];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign ramDataOut = pipe[RD_LAT-1];

   typedef struct {
      bit          side;
      bit          we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] exp_rd [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input bit side, input bit r, input bit w, input logic [7:0] a, input logic [31:0] d);
      if (side) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
      else      begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
   endtask

   function automatic int txn_len(input bit w);
      return w ? 3 : 3 + RD_LAT;
   endfunction

   // scoreboard: pops one entry per ack and checks strobes, timing and data
   initial begin
      exp_t       e;
      int         strobes = 0;
      logic [1:0] prev_ack = 2'b00;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            strobes  = 0;
            prev_ack = 2'b00;
            continue;
         end
         if (ramWrEnable && sb.size() > 0) begin
            strobes++;
            chk("wr_addr", 32'(ramAddr), 32'(sb[0].addr));
            chk("wr_data", ramDataIn, sb[0].wdata);
         end
         if (ack0 || ack1) begin
            chk("ack_width", 32'({ack1, ack0} & prev_ack), 32'd0);
            if (sb.size() == 0) begin
               chk("spurious_ack", 32'({ack1, ack0}), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ack_side", 32'({ack1, ack0}), e.side ? 32'd2 : 32'd1);
               chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
               chk("wr_strobes", 32'(strobes), e.we ? 32'd1 : 32'd0);
               strobes = 0;
               if (!e.we) exp_rd[e.side] = e.rdata;
               chk("rdata0", rdata0, exp_rd[0]);
               chk("rdata1", rdata1, exp_rd[1]);
            end
         end
         prev_ack = {ack1, ack0};
      end
   end

   task automatic single(input bit side, input bit w, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] r);
      exp_t e;
      bit   got = 0;
      @(negedge clk); #1;
      e.side = side; e.we = w; e.addr = a; e.wdata = d; e.rdata = r;
      e.ack_cyc = cyc + txn_len(w) - 1;
      sb.push_back(e);
      drive(side, 1'b1, w, a, d);
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         got = side ? ack1 : ack0;
      end
      #1 drive(side, 1'b0, w, a, d);
      chk("single_done", 32'(got), 32'd1);
   endtask

   // both requesters held high for n transactions each; grants alternate from 0
   task automatic pair(input int n,
                       input bit w0, input logic [7:0] a0, input logic [31:0] d0, input logic [31:0] r0,
                       input bit w1, input logic [7:0] a1, input logic [31:0] d1, input logic [31:0] r1);
      exp_t e;
      int   t;
      int   c0 = 0, c1 = 0;
      @(negedge clk); #1;
      t = cyc;
      for (int k = 0; k < 2 * n; k++) begin
         e.side  = k[0];
         e.we    = e.side ? w1 : w0;
         e.addr  = e.side ? a1 : a0;
         e.wdata = e.side ? d1 : d0;
         e.rdata = e.side ? r1 : r0;
         e.ack_cyc = t + txn_len(e.we) - 1;
         t = t + txn_len(e.we);
         sb.push_back(e);
      end
      drive(1'b0, 1'b1, w0, a0, d0);
      drive(1'b1, 1'b1, w1, a1, d1);
      for (int k = 0; k < 100 && (c0 < n || c1 < n); k++) begin
         @(negedge clk);
         if (ack0) c0++;
         if (ack1) c1++;
         #1;
         if (c0 >= n) req0 = 1'b0;
         if (c1 >= n) req1 = 1'b0;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      chk("pair_done0", 32'(c0), 32'(n));
      chk("pair_done1", 32'(c1), 32'(n));
   endtask

   typedef struct {
      bit          side;
      bit          we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } vec_t;

   initial begin
      vec_t vecs [9];
      vecs[0] = '{1'b0, 1'b1, 8'h00, 32'hC0FFEE00, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 8'h00, 32'h0,        32'hC0FFEE00};
      vecs[2] = '{1'b1, 1'b1, 8'hFF, 32'h12345678, 32'h0};
      vecs[3] = '{1'b0, 1'b0, 8'hFF, 32'h0,        32'h12345678};
      vecs[4] = '{1'b0, 1'b1, 8'h80, 32'hA5A5A5A5, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 8'h80, 32'h0,        32'hA5A5A5A5};
      vecs[6] = '{1'b1, 1'b1, 8'h80, 32'hFFFFFFFF, 32'h0};
      vecs[7] = '{1'b0, 1'b0, 8'h80, 32'h0,        32'hFFFFFFFF};
      vecs[8] = '{1'b1, 1'b1, 8'h78, 32'h78787878, 32'h0};

      // reset state
      #2;
      chk("rst_ack0", 32'(ack0), 32'd0);
      chk("rst_ack1", 32'(ack1), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_we", 32'(ramWrEnable), 32'd0);
      chk("rst_addr", 32'(ramAddr), 32'd0);
      chk("rst_din", ramDataIn, 32'd0);
      chk("rst_rdata0", rdata0, 32'd0);
      chk("rst_rdata1", rdata1, 32'd0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      foreach (vecs[i])
         single(vecs[i].side, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);

      // asynchronous reset mid-transaction with both requests high
      @(negedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_we", 32'(ramWrEnable), 32'd0);
      chk("arst_acks", 32'({ack1, ack0}), 32'd0);
      chk("arst_addr", 32'(ramAddr), 32'd0);
      chk("arst_rdata0", rdata0, 32'd0);
      chk("arst_rdata1", rdata1, 32'd0);
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_we", 32'(ramWrEnable), 32'd0);
      end

      // simultaneous requests after reset: requester 0 wins the first tie
      pair(1, 1'b1, 8'h01, 32'hDEADBEEF, 32'h0, 1'b0, 8'h01, 32'h0, 32'hDEADBEEF);

      // continuously held requests alternate 0,1,0,1
      pair(2, 1'b0, 8'h01, 32'h0, 32'hDEADBEEF, 1'b1, 8'h21, 32'h22222222, 32'h0);

      // reset during the WAIT of a read of 0x78
      @(negedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 8'h78, 32'h0);
      repeat (2) @(negedge clk);
      chk("wait_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1 req0 = 1'b0;
      chk("wrst_ack0", 32'(ack0), 32'd0);
      chk("wrst_busy", 32'(busy), 32'd0);
      chk("wrst_rdata0", rdata0, 32'd0);
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      @(negedge clk); #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_abort_rdata0", rdata0, 32'd0);
      single(1'b0, 1'b0, 8'h78, 32'h0, 32'h78787878);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
